// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// The GPR index width and the scoreboard reload depth are defined here.
package pipeline_hazard_controller_pkg;

  localparam int unsigned GPR_W            = 5;
  localparam int unsigned NUM_GPR          = 32;
  localparam int unsigned WB_DEPTH_DEFAULT = 3;
  localparam int unsigned SB_CNT_W         = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_scoreboard_counter.sv
// One scoreboard entry: a 2-bit down-counter that reloads on i_set.
// A set wins over the decrement, and o_busy flags a pending write.
module scoreboard_counter
  import pipeline_hazard_controller_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_set,
  input  logic [SB_CNT_W-1:0] i_load,
  output logic                o_busy
);

  logic [SB_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_set) begin
      r_cnt <= i_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - SB_CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Interlock and redirect control for a 5-stage pipeline without forwarding.
// Stalls DEC until its sources have been written back; flushes on an EX redirect.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [GPR_W-1:0] DecRs,
  input  logic [GPR_W-1:0] DecRt,
  input  logic             DecUsesRs,
  input  logic             DecUsesRt,
  input  logic             DecReadsHiLo,
  input  logic             DecRegWrite,
  input  logic [GPR_W-1:0] DecRegDst,
  input  logic             DecHiLoWrite,
  input  logic             ExRedirect,
  output logic             PCWrite,
  output logic             IfDecWrite,
  output logic             IfDecFlush,
  output logic             DecExBubble,
  output logic             Issue,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [SB_CNT_W-1:0] LoadVal = SB_CNT_W'(WB_DEPTH);

  logic [NUM_GPR-1:0] w_busy;
  logic               w_hilo_busy;
  logic               w_hazard;
  logic               w_issue;
  logic               w_gpr_set_en;
  state_t             r_state;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  // Register 0 is hardwired zero, so it never carries a pending write.
  assign w_busy[0] = 1'b0;

  assign w_gpr_set_en = w_issue & DecRegWrite;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_gpr_sb
    scoreboard_counter u_cnt (
      .i_clk   (Clk),
      .i_rst_n (Rst),
      .i_set   (w_gpr_set_en && (DecRegDst == GPR_W'(g))),
      .i_load  (LoadVal),
      .o_busy  (w_busy[g])
    );
  end

  scoreboard_counter u_hilo_cnt (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_set   (w_issue & DecHiLoWrite),
    .i_load  (LoadVal),
    .o_busy  (w_hilo_busy)
  );

  assign w_hazard = (DecUsesRs && (DecRs != '0) && w_busy[DecRs]) ||
                    (DecUsesRt && (DecRt != '0) && w_busy[DecRt]) ||
                    (DecReadsHiLo && w_hilo_busy);

  always_comb begin
    PCWrite     = 1'b1;
    IfDecWrite  = 1'b1;
    IfDecFlush  = 1'b0;
    DecExBubble = 1'b0;
    w_issue     = 1'b1;
    if (ExRedirect) begin
      // Redirect overrides a hazard: the DEC instruction is wrong-path anyway.
      IfDecFlush  = 1'b1;
      DecExBubble = 1'b1;
      w_issue     = 1'b0;
    end else if (w_hazard) begin
      PCWrite     = 1'b0;
      IfDecWrite  = 1'b0;
      DecExBubble = 1'b1;
      w_issue     = 1'b0;
    end
  end

  assign Issue = w_issue;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (ExRedirect) begin
        r_state <= ST_REDIRECT;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_hazard) begin
        r_state <= ST_STALL;
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_state <= ST_RUN;
      end
    end
  end

  assign State      = r_state;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench: each applied vector pushes its hand-computed response,
// and a negedge monitor pops and compares it against the DUT.
module tb_pipeline_hazard_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  DecRs, DecRt, DecRegDst;
  logic        DecUsesRs, DecUsesRt, DecReadsHiLo, DecRegWrite, DecHiLoWrite, ExRedirect;
  logic        PCWrite, IfDecWrite, IfDecFlush, DecExBubble, Issue;
  logic [1:0]  State;
  logic [31:0] StallCount, FlushCount;

  int n_cmp = 0;
  int n_bad = 0;

  // {PCWrite, IfDecWrite, IfDecFlush, DecExBubble, Issue}
  localparam logic [4:0] E_RUN = 5'b11001;
  localparam logic [4:0] E_STL = 5'b00010;
  localparam logic [4:0] E_RED = 5'b11110;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs, rt;
    logic        urs, urt, rhl, rw;
    logic [4:0]  dst;
    logic        whl, redir;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [31:0] stall, flc;
  } vec_t;

  typedef struct packed {
    int          idx;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [31:0] stall, flc;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  pipeline_hazard_controller #(
    .WB_DEPTH (3),
    .CNT_W    (32)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .DecRs        (DecRs),
    .DecRt        (DecRt),
    .DecUsesRs    (DecUsesRs),
    .DecUsesRt    (DecUsesRt),
    .DecReadsHiLo (DecReadsHiLo),
    .DecRegWrite  (DecRegWrite),
    .DecRegDst    (DecRegDst),
    .DecHiLoWrite (DecHiLoWrite),
    .ExRedirect   (ExRedirect),
    .PCWrite      (PCWrite),
    .IfDecWrite   (IfDecWrite),
    .IfDecFlush   (IfDecFlush),
    .DecExBubble  (DecExBubble),
    .Issue        (Issue),
    .State        (State),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic rst, input int rs, input int rt, input logic urs,
                              input logic urt, input logic rhl, input logic rw, input int dst,
                              input logic whl, input logic redir, input logic [4:0] ctl,
                              input int st, input int stall, input int flc);
    vec_t v;
    v.rst = rst; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.rhl = rhl;
    v.rw = rw; v.dst = 5'(dst); v.whl = whl; v.redir = redir; v.ctl = ctl;
    v.st = 2'(st); v.stall = 32'(stall); v.flc = 32'(flc);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("ctl", e.idx, 32'({PCWrite, IfDecWrite, IfDecFlush, DecExBubble, Issue}),
            32'(e.ctl));
      check("state", e.idx, 32'(State), 32'(e.st));
      check("stall_cnt", e.idx, StallCount, e.stall);
      check("flush_cnt", e.idx, FlushCount, e.flc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //             rst rs rt urs urt rhl rw dst whl red ctl    st stall flc
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0));  // 0 in reset
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 3, 0, 0, E_RUN, 0, 0, 0));  // 1 add $3,$1,$2
    vecs.push_back(mk(1, 4, 5, 1, 1, 0, 1, 6, 0, 0, E_RUN, 0, 0, 0));  // 2 add $6,$4,$5
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0));  // 3 nop
    vecs.push_back(mk(1, 8, 9, 1, 1, 0, 1, 7, 0, 0, E_RUN, 0, 0, 0));  // 4 add $7
    vecs.push_back(mk(1, 7, 1, 1, 1, 0, 1, 4, 0, 0, E_STL, 0, 0, 0));  // 5 sub $4,$7,$1
    vecs.push_back(mk(1, 7, 1, 1, 1, 0, 1, 4, 0, 0, E_STL, 1, 1, 0));  // 6
    vecs.push_back(mk(1, 7, 1, 1, 1, 0, 1, 4, 0, 0, E_STL, 1, 2, 0));  // 7
    vecs.push_back(mk(1, 7, 1, 1, 1, 0, 1, 4, 0, 0, E_RUN, 1, 3, 0));  // 8 issues
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, E_RUN, 0, 3, 0));  // 9 write $0
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 9, 0, 0, E_RUN, 0, 3, 0));  // 10 read $0
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, E_RUN, 0, 3, 0));  // 11 mult
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, E_STL, 0, 3, 0));  // 12 mflo $5
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, E_STL, 1, 4, 0));  // 13
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, E_STL, 1, 5, 0));  // 14
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 5, 0, 0, E_RUN, 1, 6, 0));  // 15 issues
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, E_RUN, 0, 6, 0));  // 16 mtlo $1
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, E_STL, 0, 6, 0));  // 17 mfhi $8
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, E_STL, 1, 7, 0));  // 18
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, E_STL, 1, 8, 0));  // 19
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, E_RUN, 1, 9, 0));  // 20 issues
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 10, 0, 0, E_RUN, 0, 9, 0)); // 21 add $10
    vecs.push_back(mk(1, 10, 0, 1, 0, 0, 1, 11, 0, 1, E_RED, 0, 9, 0)); // 22 redirect+hazard
    vecs.push_back(mk(1, 11, 0, 1, 0, 0, 1, 12, 0, 0, E_RUN, 2, 9, 1)); // 23 $11 not tracked
    vecs.push_back(mk(1, 1, 2, 1, 1, 0, 1, 3, 0, 0, E_RUN, 0, 9, 1));  // 24 add $3
    vecs.push_back(mk(1, 3, 0, 1, 0, 0, 1, 13, 0, 0, E_STL, 0, 9, 1)); // 25 read $3
    vecs.push_back(mk(1, 3, 0, 1, 0, 0, 1, 13, 0, 0, E_STL, 1, 10, 1)); // 26 cnt[$3]=2
    vecs.push_back(mk(0, 3, 0, 1, 0, 0, 1, 13, 0, 0, E_RUN, 0, 0, 0)); // 27 reset mid-stall
    vecs.push_back(mk(1, 3, 0, 1, 0, 0, 1, 13, 0, 0, E_RUN, 0, 0, 0)); // 28 no residual
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN, 0, 0, 0));  // 29 nop

    Rst = 1'b0;
    {DecRs, DecRt, DecRegDst} = '0;
    {DecUsesRs, DecUsesRt, DecReadsHiLo, DecRegWrite, DecHiLoWrite, ExRedirect} = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge Clk);
      #1;
      Rst          = vecs[i].rst;
      DecRs        = vecs[i].rs;
      DecRt        = vecs[i].rt;
      DecUsesRs    = vecs[i].urs;
      DecUsesRt    = vecs[i].urt;
      DecReadsHiLo = vecs[i].rhl;
      DecRegWrite  = vecs[i].rw;
      DecRegDst    = vecs[i].dst;
      DecHiLoWrite = vecs[i].whl;
      ExRedirect   = vecs[i].redir;
      e.idx = i; e.ctl = vecs[i].ctl; e.st = vecs[i].st;
      e.stall = vecs[i].stall; e.flc = vecs[i].flc;
      exp_q.push_back(e);
    end

    repeat (2) @(posedge Clk);
    check("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
